// File: rtl/fir_tap_sched_if.sv
// rtl/fir_tap_sched_if.sv - control, coefficient-load handshake and SRAM/MAC strobes of fir_tap_sched
interface fir_tap_sched_if #(
    parameter int COEF_W = 16
);
    logic              iEnable;
    logic              iCoeffUpdateFlag;
    logic              iCoeffValid;
    logic [COEF_W-1:0] iCoeffData;
    logic              oCoeffReady;
    logic              oUpdateDone;
    logic              oCsnRam;
    logic              oWrnRam;
    logic [1:0]        oRamSel;
    logic [3:0]        oAddrRam;
    logic [COEF_W-1:0] oWtDtRam;
    logic              oEnSample600k;
    logic              oAccClr;
    logic              oEnMul;
    logic              oEnAdd;
    logic              oEnSum;
    logic              oFirOutValid;

    modport master (
        output iEnable, iCoeffUpdateFlag, iCoeffValid, iCoeffData,
        input  oCoeffReady, oUpdateDone, oCsnRam, oWrnRam, oRamSel, oAddrRam, oWtDtRam,
        input  oEnSample600k, oAccClr, oEnMul, oEnAdd, oEnSum, oFirOutValid
    );

    modport slave (
        input  iEnable, iCoeffUpdateFlag, iCoeffValid, iCoeffData,
        output oCoeffReady, oUpdateDone, oCsnRam, oWrnRam, oRamSel, oAddrRam, oWtDtRam,
        output oEnSample600k, oAccClr, oEnMul, oEnAdd, oEnSum, oFirOutValid
    );
endinterface

// File: rtl/fir_tap_sched.sv
// rtl/fir_tap_sched.sv - per-sample SRAM read / MAC phase scheduler with coefficient bank loader
module fir_tap_sched #(
    parameter int DIV    = 20,
    parameter int TAPS   = 10,
    parameter int BANKS  = 4,
    parameter int COEF_W = 16
) (
    input  logic           iClk12M,
    input  logic           iRst,
    fir_tap_sched_if.slave bus
);
    localparam int NCOEF = TAPS * BANKS;
    localparam int PH_W  = $clog2(DIV);
    localparam int IDX_W = $clog2(NCOEF + 1);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DIV - 1);
    localparam logic [PH_W-1:0]  PH_TAPS  = PH_W'(TAPS);
    localparam logic [PH_W-1:0]  PH_ADDE  = PH_W'(TAPS + 1);
    localparam logic [PH_W-1:0]  PH_SUM   = PH_W'(TAPS + 2);
    localparam logic [PH_W-1:0]  PH_OUT   = PH_W'(TAPS + 3);
    localparam logic [IDX_W-1:0] IDX_TAPS = IDX_W'(TAPS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCOEF - 1);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NCOEF);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [PH_W-1:0]   r_phase, w_phase_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic              w_accept;

    logic              w_csn, w_wrn, w_ready, w_done;
    logic              w_sample, w_clr, w_mul, w_add, w_sum, w_fout;
    logic [1:0]        w_sel;
    logic [3:0]        w_addr;
    logic [COEF_W-1:0] w_wdata;

    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Outputs are decoded from the next state/phase so that the registered strobes line up with the phase counter.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = '0;
        w_idx_nxt   = '0;
        w_accept    = 1'b0;
        w_csn       = 1'b1;
        w_wrn       = 1'b1;
        w_sel       = 2'd0;
        w_addr      = 4'd0;
        w_wdata     = '0;
        w_done      = 1'b0;
        w_sample    = 1'b0;
        w_clr       = 1'b0;
        w_mul       = 1'b0;
        w_add       = 1'b0;
        w_sum       = 1'b0;
        w_fout      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.iCoeffUpdateFlag) begin
                    w_state_nxt = S_UPDATE;
                end else if (bus.iEnable) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_UPDATE: begin
                w_idx_nxt = r_idx;
                w_accept  = bus.iCoeffValid && bus.oCoeffReady;
                if (w_accept) begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                    w_csn     = 1'b0;
                    w_wrn     = 1'b0;
                    w_sel     = 2'(r_idx / IDX_TAPS);
                    w_addr    = 4'(r_idx % IDX_TAPS);
                    w_wdata   = bus.iCoeffData;
                    w_done    = (r_idx == IDX_LAST);
                end
                if (!bus.iCoeffUpdateFlag) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end
            end
            S_RUN: begin
                // Mode changes wait for the sample boundary so a started schedule always completes.
                if (r_phase == PH_LAST) begin
                    if (bus.iCoeffUpdateFlag) begin
                        w_state_nxt = S_UPDATE;
                    end else if (!bus.iEnable) begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_state_nxt == S_RUN) begin
            if (w_phase_nxt < PH_TAPS) begin
                w_csn  = 1'b0;
                w_addr = 4'(w_phase_nxt);
            end
            w_clr    = (w_phase_nxt == '0);
            w_mul    = (w_phase_nxt >= PH_W'(1)) && (w_phase_nxt <= PH_TAPS);
            w_add    = (w_phase_nxt >= PH_W'(2)) && (w_phase_nxt <= PH_ADDE);
            w_sum    = (w_phase_nxt == PH_SUM);
            w_fout   = (w_phase_nxt == PH_OUT);
            w_sample = (w_phase_nxt == PH_LAST);
        end

        w_ready = (w_state_nxt == S_UPDATE) && (w_idx_nxt < IDX_END);
    end

    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            bus.oCsnRam       <= 1'b1;
            bus.oWrnRam       <= 1'b1;
            bus.oRamSel       <= 2'd0;
            bus.oAddrRam      <= 4'd0;
            bus.oWtDtRam      <= '0;
            bus.oCoeffReady   <= 1'b0;
            bus.oUpdateDone   <= 1'b0;
            bus.oEnSample600k <= 1'b0;
            bus.oAccClr       <= 1'b0;
            bus.oEnMul        <= 1'b0;
            bus.oEnAdd        <= 1'b0;
            bus.oEnSum        <= 1'b0;
            bus.oFirOutValid  <= 1'b0;
        end else begin
            bus.oCsnRam       <= w_csn;
            bus.oWrnRam       <= w_wrn;
            bus.oRamSel       <= w_sel;
            bus.oAddrRam      <= w_addr;
            bus.oWtDtRam      <= w_wdata;
            bus.oCoeffReady   <= w_ready;
            bus.oUpdateDone   <= w_done;
            bus.oEnSample600k <= w_sample;
            bus.oAccClr       <= w_clr;
            bus.oEnMul        <= w_mul;
            bus.oEnAdd        <= w_add;
            bus.oEnSum        <= w_sum;
            bus.oFirOutValid  <= w_fout;
        end
    end
endmodule

// File: tb/tb_fir_tap_sched.sv
// tb/tb_fir_tap_sched.sv - vector table, directed corner sequences and randomized model check of fir_tap_sched
module tb_fir_tap_sched;
    localparam int DIV  = 20;
    localparam int TAPS = 10;
    localparam int NC   = 40;
    localparam int M_IDLE = 0, M_UPD = 1, M_RUN = 2;

    typedef struct packed {
        logic        csn, wrn;
        logic [1:0]  sel;
        logic [3:0]  addr;
        logic [15:0] wd;
        logic        rdy, done, samp, clr, mul, add, sum, fv;
    } outs_t;

    typedef struct {
        logic        rst, en, fl, v;
        logic [15:0] d;
        outs_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    fir_tap_sched_if #(.COEF_W(16)) bus ();

    fir_tap_sched #(.DIV(DIV), .TAPS(TAPS), .BANKS(4), .COEF_W(16)) dut (
        .iClk12M (clk),
        .iRst    (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    outs_t run_sched [DIV];
    outs_t m_exp;
    int    m_mode, m_ph, m_idx;
    vec_t  tab [12];

    function automatic outs_t mk(input logic csn, wrn, input int sel, addr, wd,
                                 input logic rdy, done, samp, clr, mul, add, sum, fv);
        outs_t o;
        o.csn = csn; o.wrn = wrn; o.sel = 2'(sel); o.addr = 4'(addr); o.wd = 16'(wd);
        o.rdy = rdy; o.done = done; o.samp = samp; o.clr = clr;
        o.mul = mul; o.add = add; o.sum = sum; o.fv = fv;
        return o;
    endfunction

    function automatic outs_t dut_outs();
        return {bus.oCsnRam, bus.oWrnRam, bus.oRamSel, bus.oAddrRam, bus.oWtDtRam,
                bus.oCoeffReady, bus.oUpdateDone, bus.oEnSample600k, bus.oAccClr,
                bus.oEnMul, bus.oEnAdd, bus.oEnSum, bus.oFirOutValid};
    endfunction

    task automatic drive(input logic r, en, fl, v, input logic [15:0] d);
        rst = r;
        bus.iEnable = en;
        bus.iCoeffUpdateFlag = fl;
        bus.iCoeffValid = v;
        bus.iCoeffData = d;
    endtask

    // Reference: mode / phase-in-period / load-count bookkeeping, outputs looked up from the sample schedule.
    task automatic model_step();
        outs_t e;
        e = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (rst) begin
            m_mode = M_IDLE; m_ph = 0; m_idx = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (bus.iCoeffUpdateFlag) m_mode = M_UPD;
                    else if (bus.iEnable) begin m_mode = M_RUN; m_ph = 0; end
                end
                M_UPD: begin
                    if (bus.iCoeffValid && m_exp.rdy) begin
                        e = mk(0, 0, m_idx / TAPS, m_idx % TAPS, int'(bus.iCoeffData),
                               0, m_idx == NC - 1, 0, 0, 0, 0, 0, 0);
                        m_idx++;
                    end
                    if (!bus.iCoeffUpdateFlag) begin m_mode = M_IDLE; m_idx = 0; end
                end
                default: begin
                    if (m_ph == DIV - 1) begin
                        m_ph = 0;
                        if (bus.iCoeffUpdateFlag) m_mode = M_UPD;
                        else if (!bus.iEnable) m_mode = M_IDLE;
                    end else begin
                        m_ph++;
                    end
                end
            endcase
            if (m_mode == M_RUN) e = run_sched[m_ph];
            e.rdy = (m_mode == M_UPD) && (m_idx < NC);
        end
        m_exp = e;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic chk_out(input string name, input outs_t exp);
        outs_t act;
        act = dut_outs();
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cycm(input string name);
        cyc();
        chk_out(name, m_exp);
    endtask

    initial begin
        int last, ns, nf, nd, first;
        outs_t idle_o;

        for (int p = 0; p < DIV; p++)
            run_sched[p] = mk(!(p < TAPS), 1, 0, (p < TAPS) ? p : 0, 0, 0, 0,
                              p == DIV - 1, p == 0, p >= 1 && p <= TAPS,
                              p >= 2 && p <= TAPS + 1, p == TAPS + 2, p == TAPS + 3);
        idle_o = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_exp = idle_o; m_mode = M_IDLE; m_ph = 0; m_idx = 0;

        tab[0]  = '{1, 0, 0, 0, 16'h0000, idle_o};
        tab[1]  = '{0, 1, 1, 0, 16'h0000, mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)};
        tab[2]  = '{0, 1, 1, 1, 16'hAAAA, mk(0, 0, 0, 0, 16'hAAAA, 1, 0, 0, 0, 0, 0, 0, 0)};
        tab[3]  = '{0, 0, 1, 1, 16'h5555, mk(0, 0, 0, 1, 16'h5555, 1, 0, 0, 0, 0, 0, 0, 0)};
        tab[4]  = '{0, 1, 0, 0, 16'h0000, idle_o};
        tab[5]  = '{0, 1, 0, 0, 16'h0000, mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)};
        tab[6]  = '{0, 1, 0, 0, 16'h0000, mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
        tab[7]  = '{0, 1, 0, 0, 16'h0000, mk(0, 1, 0, 2, 0, 0, 0, 0, 0, 1, 1, 0, 0)};
        tab[8]  = '{1, 1, 0, 0, 16'h0000, idle_o};
        tab[9]  = '{0, 1, 0, 0, 16'h0000, mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0)};
        tab[10] = '{0, 0, 0, 0, 16'h0000, mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0)};
        tab[11] = '{1, 0, 0, 0, 16'h0000, idle_o};

        for (int i = 0; i < 12; i++) begin
            drive(tab[i].rst, tab[i].en, tab[i].fl, tab[i].v, tab[i].d);
            cyc();
            chk_out($sformatf("vec%0d", i), tab[i].exp);
        end

        // Free run: 100 enabled cycles.
        drive(1, 0, 0, 0, 0); cycm("fr_reset");
        drive(0, 1, 0, 0, 0);
        last = -1; ns = 0; nf = 0; first = 0;
        for (int k = 1; k <= 100; k++) begin
            cycm("free_run");
            if ((k - 1) % DIV < TAPS) chk("read_addr", int'(bus.oAddrRam), (k - 1) % DIV);
            if (bus.oEnSample600k) begin
                ns++;
                if (last >= 0) chk("sample_gap", k - last, DIV);
                else first = k;
                last = k;
            end
            if (bus.oFirOutValid) begin
                nf++;
                chk("outvalid_phase", (k - 1) % DIV, 13);
            end
        end
        chk("first_sample", first, 20);
        chk("sample_count", ns, 5);
        chk("outvalid_count", nf, 5);

        // Full coefficient load plus a 41st write attempt.
        drive(1, 0, 0, 0, 0); cycm("ld_reset");
        drive(0, 0, 1, 0, 0); cycm("ld_enter");
        nd = 0;
        for (int i = 0; i < NC; i++) begin
            drive(0, 0, 1, 1, 16'(i));
            cycm("load");
            chk("wr_strobe", int'({bus.oCsnRam, bus.oWrnRam}), 0);
            chk("wr_sel", int'(bus.oRamSel), i / TAPS);
            chk("wr_addr", int'(bus.oAddrRam), i % TAPS);
            chk("wr_data", int'(bus.oWtDtRam), i);
            if (i == NC - 1) chk("done_pulse", int'(bus.oUpdateDone), 1);
            nd += int'(bus.oUpdateDone);
        end
        drive(0, 0, 1, 1, 16'h0077);
        for (int i = 0; i < 3; i++) begin
            cycm("extra_write");
            chk("no_41st_write", int'(bus.oCsnRam), 1);
            chk("ready_low", int'(bus.oCoeffReady), 0);
            nd += int'(bus.oUpdateDone);
        end
        chk("done_once", nd, 1);
        drive(0, 0, 0, 0, 0); cycm("ld_exit");

        // Early exit after 15 writes, then re-entry.
        drive(1, 0, 0, 0, 0); cycm("ee_reset");
        drive(0, 0, 1, 0, 0); cycm("ee_enter");
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            drive(0, 0, 1, 1, 16'(i + 100));
            cycm("early_load");
            nd += int'(bus.oUpdateDone);
        end
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycm("early_exit");
            nd += int'(bus.oUpdateDone);
        end
        chk("early_no_done", nd, 0);
        drive(0, 0, 1, 0, 0); cycm("reenter");
        drive(0, 0, 1, 1, 16'hBEEF); cycm("reenter_write");
        chk("reentry_sel", int'(bus.oRamSel), 0);
        chk("reentry_addr", int'(bus.oAddrRam), 0);
        chk("reentry_data", int'(bus.oWtDtRam), 16'hBEEF);
        drive(0, 0, 0, 0, 0); cycm("reenter_exit");

        // Update requested mid-sample at phase 5.
        drive(1, 0, 0, 0, 0); cycm("mu_reset");
        drive(0, 1, 0, 0, 0);
        for (int k = 1; k <= 6; k++) cycm("mu_run");
        chk("phase5_addr", int'(bus.oAddrRam), 5);
        drive(0, 1, 1, 0, 0);
        ns = 0;
        for (int k = 7; k <= 20; k++) begin
            cycm("mu_finish");
            ns += int'(bus.oEnSample600k);
        end
        chk("midrun_boundary_sample", ns, 1);
        cycm("mu_enter");
        chk("update_entered", int'(bus.oCoeffReady), 1);
        ns = 0;
        for (int k = 0; k < 10; k++) begin
            cycm("mu_hold");
            ns += int'(bus.oEnSample600k);
        end
        chk("no_sample_in_update", ns, 0);

        // Reset at phase 7 with enable held.
        drive(1, 0, 0, 0, 0); cycm("rm_reset");
        drive(0, 1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) cycm("rm_run");
        chk("pre_reset_mul", int'(bus.oEnMul), 1);
        drive(1, 1, 0, 0, 0); cycm("rm_hit");
        chk("rst_mul", int'(bus.oEnMul), 0);
        chk("rst_csn", int'(bus.oCsnRam), 1);
        drive(0, 1, 0, 0, 0); cycm("rm_resume");
        chk("resume_clr", int'(bus.oAccClr), 1);
        chk("resume_addr", int'(bus.oAddrRam), 0);
        chk("resume_csn", int'(bus.oCsnRam), 0);

        // Randomized traffic against the reference model.
        drive(1, 0, 0, 0, 0); cycm("rnd_reset");
        begin
            logic en, fl;
            en = 1'b0; fl = 1'b0;
            for (int k = 0; k < 3000; k++) begin
                if ($urandom_range(39, 0) == 0) en = ~en;
                if ($urandom_range(119, 0) == 0) fl = ~fl;
                drive($urandom_range(199, 0) == 0, en, fl, 1'($urandom), 16'($urandom));
                cycm("random");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fir_tap_sched.md
FIR_TAP_SCHED -- requirements
Module: fir_tap_sched

Interface
- REQ-001 Parameter DIV, 20: iClk12M cycles per sample period; 12 MHz / 20 = 600 kHz.
- REQ-002 Parameter TAPS, 10: taps per coefficient bank.
- REQ-003 Parameter BANKS, 4: number of coefficient banks (40 taps total).
- REQ-004 Parameter COEF_W, 16: coefficient width.
- REQ-005 iClk12M  in  1  single clock; all logic on rising edge.
- REQ-006 iRst  in  1  reset; synchronous, active-high.
- REQ-007 iEnable  in  1  run request.
- REQ-008 iCoeffUpdateFlag  in  1  coefficient-load mode request.
- REQ-009 iCoeffValid  in  1  write coefficient on iCoeffData this cycle.
- REQ-010 iCoeffData  in  COEF_W  coefficient word.
- REQ-011 oCoeffReady  out  1  coefficient write accepted when high with iCoeffValid.
- REQ-012 oUpdateDone  out  1  one-cycle pulse after coefficient 39 is written.
- REQ-013 oCsnRam  out  1  SRAM chip select, active-low.
- REQ-014 oWrnRam  out  1  SRAM write strobe, active-low.
- REQ-015 oRamSel  out  2  bank select.
- REQ-016 oAddrRam  out  4  SRAM address.
- REQ-017 oWtDtRam  out  COEF_W  SRAM write data.
- REQ-018 oEnSample600k  out  1  sample strobe to the delay chain.
- REQ-019 oAccClr, oEnMul, oEnAdd, oEnSum  out  1 each  MAC phase controls.
- REQ-020 oFirOutValid  out  1  filter output valid pulse.

Function
- REQ-021 The FSM SHALL have states IDLE, UPDATE and RUN.
- REQ-022 Transitions:
  - IDLE->UPDATE when iCoeffUpdateFlag=1 (priority over iEnable).
  - IDLE->RUN when iEnable=1 and iCoeffUpdateFlag=0.
  - UPDATE->IDLE when iCoeffUpdateFlag=0.
  - RUN->IDLE or RUN->UPDATE only at sample boundary (phase counter = DIV-1) when iEnable=0 or iCoeffUpdateFlag=1.
- REQ-023 In RUN, the phase counter SHALL count 0..DIV-1 and wrap; it SHALL be held at 0 outside RUN.
- REQ-024 In RUN, oEnSample600k SHALL be 1 exactly when the phase counter = DIV-1; it SHALL be 0 in all other states.
- REQ-025 Read schedule: at phases 0..TAPS-1, oCsnRam=0, oWrnRam=1 and oAddrRam=phase; oRamSel=0 (all banks read in parallel).
- REQ-026 MAC controls, with 1-cycle SRAM read latency:
  - oAccClr=1 at phase 0.
  - oEnMul=1 at phases 1..TAPS.
  - oEnAdd=1 at phases 2..TAPS+1.
  - oEnSum=1 at phase TAPS+2.
  - oFirOutValid=1 at phase TAPS+3 (phase 13).
- REQ-027 In UPDATE, oCoeffReady=1 while the write index < 40.
- REQ-028 Each accepted write (iCoeffValid & oCoeffReady) SHALL, in the same cycle:
  - drive oCsnRam=0, oWrnRam=0;
  - drive oRamSel=index/TAPS, oAddrRam=index%TAPS, oWtDtRam=iCoeffData;
  - increment the index.
- REQ-029 When write index 39 is accepted, oUpdateDone SHALL pulse on the next cycle and oCoeffReady SHALL go 0; further iCoeffValid SHALL be ignored with no SRAM access.
- REQ-030 Leaving UPDATE SHALL reset the write index to 0; an early exit (index < 40) SHALL produce no oUpdateDone.
- REQ-031 When no access is scheduled: oCsnRam=1, oWrnRam=1, oAddrRam=0, oRamSel=0, oWtDtRam=0.
- REQ-032 All outputs SHALL be registered.

Reset
- REQ-033 While iRst=1 at a clock edge, the block SHALL enter IDLE with phase counter=0 and write index=0.
- REQ-034 Reset output values:
  - oCsnRam=1, oWrnRam=1.
  - All other outputs 0.
- REQ-035 Reset SHALL take effect mid-RUN or mid-UPDATE within one cycle, discarding the partial sample schedule or coefficient load.

Verification
- REQ-036 Free run: reset, then iEnable=1 for 100 cycles -> oEnSample600k pulses every 20 cycles; oAddrRam steps 0..9 at phases 0..9; oFirOutValid at phase 13 of every period.
- REQ-037 Coefficient load: iCoeffUpdateFlag=1, 40 writes of data=index -> writes land at (sel,addr) (0,0)..(3,9) with matching data; oUpdateDone pulses once; a 41st iCoeffValid causes no SRAM write.
- REQ-038 Early exit: drop iCoeffUpdateFlag after 15 writes -> no oUpdateDone; re-entering UPDATE restarts at bank 0, address 0.
- REQ-039 Mid-run update: assert iCoeffUpdateFlag at phase 5 -> current schedule completes through phase 19; UPDATE entered after the boundary; oEnSample600k then stays 0.
- REQ-040 Simultaneous requests: iEnable=1 and iCoeffUpdateFlag=1 in IDLE -> UPDATE entered.
- REQ-041 Reset mid-operation: iRst=1 at phase 7 for one cycle -> next cycle oEnMul=0, oCsnRam=1, phase counter=0; with iEnable held high, RUN resumes one cycle after release.
